// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: debounces one raw push-button and produces a clean
// level plus a single-clock press strobe for the game FSM.
//
// Ports:
//   Clk100MHz  in   system clock
//   reset_n    in   asynchronous, active-low reset
//   tick_en    in   single-cycle enable (nominally Clk1KHzEn)
//   btn_in     in   raw, asynchronous, bouncy button (1 = pressed)
//   btn_level  out  debounced button state
//   btn_pulse  out  one-clock strobe per accepted press (and repeat)
//
// Optional build macro: AUTOREPEAT_EN
//   When defined, holding the button produces extra pulses after
//   REPEAT_DELAY ticks and then every REPEAT_PERIOD ticks.
//   When undefined, no repeat logic exists: one pulse per press.

module btn_debounce_pulse #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int CNT_W          = 8,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 200
) (
    input  logic Clk100MHz,
    input  logic reset_n,
    input  logic tick_en,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    // Parameter legality is checked at elaboration time so a bad
    // instantiation fails loudly instead of silently misbehaving.
    if ((DEBOUNCE_TICKS < 1) || (DEBOUNCE_TICKS > 255) ||
        (CNT_W < 1) || (CNT_W > 16) ||
        ((DEBOUNCE_TICKS - 1) >= (1 << CNT_W)) ||
        (REPEAT_DELAY < 1) || (REPEAT_DELAY > 1023) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > 1023))
    begin : g_bad_param
        $error("btn_debounce_pulse: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_TICKS - 1);

    // ------------------------------------------------------------
    // Two-flop synchronizer: the FSM only ever looks at btn_s.
    // ------------------------------------------------------------
    logic btn_meta;
    logic btn_s;

    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // ------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_hit;
    logic             rpt_hit;
    logic             level_nxt;
    logic             pulse_nxt;

    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
            btn_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_hit = 1'b0;
        unique case (state)
            IDLE: begin
                // A tick in the exit cycle is deliberately not counted.
                if (btn_s) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                // A bounce wins over a coincident tick.
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (tick_en) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        press_hit = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (tick_en) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The level is high for the whole accepted-press interval,
    // including the release check, so bounces on release are hidden.
    assign level_nxt = (state_nxt == HELD) ||
                       (state_nxt == RELEASE_CHK);

    // Gating with the current pulse keeps the strobe to one clock
    // even if a repeat lands right behind the press pulse.
    assign pulse_nxt = (press_hit | rpt_hit) & ~btn_pulse;

`ifdef AUTOREPEAT_EN
    // ------------------------------------------------------------
    // Auto-repeat: rpt_ph selects the first-delay or period phase,
    // so REPEAT_PERIOD may be larger than REPEAT_DELAY.
    // ------------------------------------------------------------
    localparam logic [9:0] RPT_DLY = 10'(REPEAT_DELAY - 1);
    localparam logic [9:0] RPT_PER = 10'(REPEAT_PERIOD - 1);

    logic [9:0] rpt_cnt;
    logic [9:0] rpt_cnt_nxt;
    logic       rpt_ph;
    logic       rpt_ph_nxt;
    logic [9:0] rpt_lim;

    assign rpt_lim = rpt_ph ? RPT_PER : RPT_DLY;

    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
            rpt_ph  <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
            rpt_ph  <= rpt_ph_nxt;
        end
    end

    // Only a fresh press clears the counter on HELD entry; a bounce
    // back from RELEASE_CHK resumes where it left off.
    always_comb begin
        rpt_cnt_nxt = rpt_cnt;
        rpt_ph_nxt  = rpt_ph;
        rpt_hit     = 1'b0;
        if (press_hit || (state == IDLE)) begin
            rpt_cnt_nxt = '0;
            rpt_ph_nxt  = 1'b0;
        end else if ((state == HELD) && btn_s && tick_en) begin
            if (rpt_cnt == rpt_lim) begin
                rpt_hit     = 1'b1;
                rpt_cnt_nxt = '0;
                rpt_ph_nxt  = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: table-driven and scoreboard bench for
// btn_debounce_pulse with DEBOUNCE_TICKS=4.

module tb_btn_debounce_pulse;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tick_en = 1'b0;
    logic btn     = 1'b0;
    logic lvl;
    logic pls;

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .DEBOUNCE_TICKS(4),
        .CNT_W(8),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) u_dut (
        .Clk100MHz(clk),
        .reset_n(rst_n),
        .tick_en(tick_en),
        .btn_in(btn),
        .btn_level(lvl),
        .btn_pulse(pls)
    );

    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   cyc         = 0;
    int   pulse_total = 0;
    int   div         = 0;
    bit   tick_always = 1'b0;
    logic prev_pls    = 1'b0;
    int   pulse_q[$];

    typedef struct {
        logic b;
        int   nt;
        logic lvl;
        int   np;
    } vec_t;

    typedef struct {
        logic lvl;
        int   np;
    } exp_t;

    vec_t tbl[14];
    exp_t exp_q[$];

    function automatic void chk(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endfunction

    // tick_en: one cycle in ten, or every cycle in fast mode
    always @(negedge clk) begin
        if (tick_always) begin
            tick_en = 1'b1;
        end else begin
            tick_en = (div == 9);
        end
        div = (div == 9) ? 0 : div + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor: records each pulse, checks it is one clock wide
    always @(negedge clk) begin
        if (pls) begin
            pulse_total++;
            pulse_q.push_back(cyc);
            chk("pulse_width_prev", int'(prev_pls), 0);
        end
        prev_pls = pls;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick_en) @(posedge clk);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int t;
        int t0;
        int got[$];
        int expo[$];
        exp_t e;

        // btn, ticks, level at end, pulses in segment
        tbl[0]  = '{1'b0, 2, 1'b0, 0};
        tbl[1]  = '{1'b1, 3, 1'b0, 0};
        tbl[2]  = '{1'b1, 1, 1'b1, 1};
        tbl[3]  = '{1'b1, 5, 1'b1, 0};
        tbl[4]  = '{1'b0, 3, 1'b1, 0};
        tbl[5]  = '{1'b0, 1, 1'b0, 0};
        tbl[6]  = '{1'b1, 3, 1'b0, 0};
        tbl[7]  = '{1'b0, 3, 1'b0, 0};
        tbl[8]  = '{1'b1, 3, 1'b0, 0};
        tbl[9]  = '{1'b1, 1, 1'b1, 1};
        tbl[10] = '{1'b0, 2, 1'b1, 0};
        tbl[11] = '{1'b1, 3, 1'b1, 0};
        tbl[12] = '{1'b0, 4, 1'b0, 0};
        tbl[13] = '{1'b0, 2, 1'b0, 0};

        // reset held with button pressed
        rst_n = 1'b0;
        btn   = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("reset_level", int'(lvl), 0);
        chk("reset_pulse", int'(pls), 0);
        wait_ticks(1);
        rst_n = 1'b1;
        p0 = pulse_total;
        wait_ticks(3);
        chk("post_reset_3t_level", int'(lvl), 0);
        chk("post_reset_3t_pulses", pulse_total - p0, 0);
        wait_ticks(1);
        chk("post_reset_4t_level", int'(lvl), 1);
        chk("post_reset_4t_pulses", pulse_total - p0, 1);
        btn = 1'b0;
        p0 = pulse_total;
        wait_ticks(4);
        chk("post_reset_rel_level", int'(lvl), 0);
        chk("post_reset_rel_pulses", pulse_total - p0, 0);

        // table: clean press, bounces on press and release
        for (int i = 0; i < 14; i++) begin
            btn = tbl[i].b;
            exp_q.push_back('{tbl[i].lvl, tbl[i].np});
            p0 = pulse_total;
            wait_ticks(tbl[i].nt);
            e = exp_q.pop_front();
            chk($sformatf("row%0d_level", i), int'(lvl), int'(e.lvl));
            chk($sformatf("row%0d_pulses", i), pulse_total - p0, e.np);
        end

        // reset mid PRESS_CHK at count 2
        btn = 1'b1;
        p0 = pulse_total;
        wait_ticks(2);
        rst_n = 1'b0;
        #1;
        chk("midpress_rst_level", int'(lvl), 0);
        wait_ticks(1);
        chk("midpress_rst_pulses", pulse_total - p0, 0);
        rst_n = 1'b1;
        p0 = pulse_total;
        wait_ticks(3);
        chk("midpress_3t_level", int'(lvl), 0);
        chk("midpress_3t_pulses", pulse_total - p0, 0);
        wait_ticks(1);
        chk("midpress_4t_level", int'(lvl), 1);
        chk("midpress_4t_pulses", pulse_total - p0, 1);

        // asynchronous reset while held, between clock edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(lvl), 0);
        chk("async_rst_pulse", int'(pls), 0);
        btn = 1'b0;
        #20;
        rst_n = 1'b1;
        wait_ticks(2);
        chk("after_async_level", int'(lvl), 0);

        // hold with tick_en always high: repeat behaviour
`ifdef AUTOREPEAT_EN
        expo = '{0, 10, 15, 20, 25, 30};
`else
        expo = '{0};
`endif
        pulse_q.delete();
        tick_always = 1'b1;
        @(negedge clk);
        #1;
        btn = 1'b1;
        t = 0;
        while (pulse_q.size() == 0 && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (pulse_q.size() == 0) begin
            chk("hold_first_pulse_seen", 0, 1);
        end else begin
            t0 = pulse_q[0];
            repeat (32) @(negedge clk);
            #1;
            got = pulse_q;
            btn = 1'b0;
            chk("hold_pulse_count", got.size(), expo.size());
            for (int i = 0; i < got.size() && i < expo.size(); i++) begin
                chk($sformatf("hold_pulse%0d_ofs", i),
                    got[i] - t0, expo[i]);
            end
        end
        btn = 1'b0;
        tick_always = 1'b0;
        wait_ticks(6);
        chk("hold_release_level", int'(lvl), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
